// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline. It selects the forwarded
// operands, runs the ALU, and captures the result, store data, destination
// and control bits in the EX/MEM pipeline register. The register can hold
// its contents (stall) or be loaded with a bubble (flush).
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [4:0]        i_shamt,
    input  logic [REG_AW-1:0] i_rt_addr,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic [3:0]        i_alu_ctl,
    input  logic              i_alu_src,
    input  logic              i_reg_dst,
    input  logic              i_reg_write,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic [1:0]        i_fwd_a,
    input  logic [1:0]        i_fwd_b,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_ex_mem_alu_result,
    output logic [DATA_W-1:0] o_ex_mem_write_data,
    output logic [REG_AW-1:0] o_ex_mem_dest,
    output logic              o_ex_mem_zero,
    output logic              o_ex_mem_reg_write,
    output logic              o_ex_mem_mem_read,
    output logic              o_ex_mem_mem_write,
    output logic              o_ex_mem_mem_to_reg,
    output logic              o_ex_mem_valid
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_write_data;
    logic [REG_AW-1:0] r_dest;
    logic              r_zero;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_valid;

    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_zero;
    logic [REG_AW-1:0] w_dest;

    // Forwarding muxes; select 10 reads the EX/MEM register, which during a
    // stall is the held value. Encoding 11 is treated like 00.
    always_comb begin
        w_fwd_a = i_rs_data;
        case (i_fwd_a)
            2'b10:   w_fwd_a = r_alu_result;
            2'b01:   w_fwd_a = i_wb_data;
            default: w_fwd_a = i_rs_data;
        endcase

        w_fwd_rt = i_rt_data;
        case (i_fwd_b)
            2'b10:   w_fwd_rt = r_alu_result;
            2'b01:   w_fwd_rt = i_wb_data;
            default: w_fwd_rt = i_rt_data;
        endcase
    end

    assign w_op_b = i_alu_src ? i_imm : w_fwd_rt;
    assign w_dest = i_reg_dst ? i_rd_addr : i_rt_addr;

    // ALU; SLL shifts the forwarded rt (not operand B), undefined codes give 0.
    always_comb begin
        w_alu_result = '0;
        case (i_alu_ctl)
            ALU_AND: w_alu_result = w_fwd_a & w_op_b;
            ALU_OR:  w_alu_result = w_fwd_a | w_op_b;
            ALU_ADD: w_alu_result = w_fwd_a + w_op_b;
            ALU_SUB: w_alu_result = w_fwd_a - w_op_b;
            ALU_SLT: w_alu_result = ($signed(w_fwd_a) < $signed(w_op_b))
                                    ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            ALU_SLL: w_alu_result = w_fwd_rt << i_shamt;
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    // EX/MEM register: reset, then flush (bubble, beats stall), then stall hold.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_alu_result <= '0;
            r_write_data <= '0;
            r_dest       <= '0;
            r_zero       <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!i_stall) begin
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_rt;
            r_dest       <= w_dest;
            r_zero       <= w_zero;
            r_reg_write  <= i_reg_write;
            r_mem_read   <= i_mem_read;
            r_mem_write  <= i_mem_write;
            r_mem_to_reg <= i_mem_to_reg;
            r_valid      <= 1'b1;
        end
    end

    assign o_ex_mem_alu_result = r_alu_result;
    assign o_ex_mem_write_data = r_write_data;
    assign o_ex_mem_dest       = r_dest;
    assign o_ex_mem_zero       = r_zero;
    assign o_ex_mem_reg_write  = r_reg_write;
    assign o_ex_mem_mem_read   = r_mem_read;
    assign o_ex_mem_mem_write  = r_mem_write;
    assign o_ex_mem_mem_to_reg = r_mem_to_reg;
    assign o_ex_mem_valid      = r_valid;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: a directed vector table, a reset sequence, and a
// randomized run compared against an arithmetic reference model.
module tb_ex_stage;

    localparam logic [3:0] AND_ = 4'b0000;
    localparam logic [3:0] OR_  = 4'b0001;
    localparam logic [3:0] ADD_ = 4'b0010;
    localparam logic [3:0] SLL_ = 4'b0100;
    localparam logic [3:0] SUB_ = 4'b0110;
    localparam logic [3:0] SLT_ = 4'b0111;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [31:0] rs_data, rt_data, imm, wb_data;
    logic [4:0]  shamt, rt_addr, rd_addr;
    logic [3:0]  alu_ctl;
    logic        alu_src, reg_dst;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] o_res, o_wd;
    logic [4:0]  o_dest;
    logic        o_zero, o_rw, o_mr, o_mw, o_m2r, o_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm), .i_shamt(shamt),
        .i_rt_addr(rt_addr), .i_rd_addr(rd_addr), .i_alu_ctl(alu_ctl),
        .i_alu_src(alu_src), .i_reg_dst(reg_dst), .i_reg_write(reg_write),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_to_reg(mem_to_reg),
        .i_fwd_a(fwd_a), .i_fwd_b(fwd_b), .i_wb_data(wb_data),
        .o_ex_mem_alu_result(o_res), .o_ex_mem_write_data(o_wd),
        .o_ex_mem_dest(o_dest), .o_ex_mem_zero(o_zero),
        .o_ex_mem_reg_write(o_rw), .o_ex_mem_mem_read(o_mr),
        .o_ex_mem_mem_write(o_mw), .o_ex_mem_mem_to_reg(o_m2r),
        .o_ex_mem_valid(o_valid)
    );

    // ctrl / e_ctrl bit order: {reg_write, mem_read, mem_write, mem_to_reg}
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [31:0] wb;
        logic [4:0]  shamt;
        logic [4:0]  rt_a;
        logic [4:0]  rd_a;
        logic [3:0]  ctl;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  ctrl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] e_res;
        logic [31:0] e_wd;
        logic [4:0]  e_dest;
        logic        e_zero;
        logic [3:0]  e_ctrl;
        logic        e_valid;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_res, input logic [31:0] e_wd,
                             input logic [4:0] e_dest, input logic e_zero,
                             input logic [3:0] e_ctrl, input logic e_valid);
        chk({tag, ".result"}, o_res, e_res);
        chk({tag, ".wdata"}, o_wd, e_wd);
        chk({tag, ".dest"}, 32'(o_dest), 32'(e_dest));
        chk({tag, ".zero"}, 32'(o_zero), 32'(e_zero));
        chk({tag, ".ctrl"}, 32'({o_rw, o_mr, o_mw, o_m2r}), 32'(e_ctrl));
        chk({tag, ".valid"}, 32'(o_valid), 32'(e_valid));
    endtask

    task automatic drive(input vec_t v);
        stall   = v.stall;   flush   = v.flush;
        rs_data = v.rs;      rt_data = v.rt;   imm = v.imm; wb_data = v.wb;
        shamt   = v.shamt;   rt_addr = v.rt_a; rd_addr = v.rd_a;
        alu_ctl = v.ctl;     alu_src = v.alu_src; reg_dst = v.reg_dst;
        {reg_write, mem_read, mem_write, mem_to_reg} = v.ctrl;
        fwd_a   = v.fa;      fwd_b   = v.fb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU written straight from the operation list.
    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] rt,
                                            input logic [4:0] sh);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (ctl)
            AND_:    return a & b;
            OR_:     return a | b;
            ADD_:    return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            SUB_:    return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            SLT_:    return (sa < sb) ? 32'd1 : 32'd0;
            SLL_:    return 32'((longint'(rt) * (64'd1 << sh)) % 64'h1_0000_0000);
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] m_res, m_wd;
    logic [4:0]  m_dest;
    logic        m_zero, m_valid;
    logic [3:0]  m_ctrl;

    initial begin
        vec_t v;
        logic [31:0] a, rtv, b, r;
        logic [3:0]  ctls [7];

        //           stall flush rs            rt            imm           wb         shamt rt_a  rd_a   ctl   src   dst   ctrl     fa    fb     e_res          e_wd          e_dest e_zero e_ctrl  e_valid
        vecs[0]  = '{1'b0,1'b0, 32'd5,        32'd7,        32'd0,        32'd0,     5'd0, 5'd9, 5'd3,  ADD_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd12,        32'd7,        5'd3,  1'b0, 4'b1000, 1'b1};
        vecs[1]  = '{1'b0,1'b0, 32'd9,        32'd9,        32'd0,        32'd0,     5'd0, 5'd4, 5'd3,  SUB_, 1'b0, 1'b0, 4'b1000, 2'd0, 2'd0,  32'd0,         32'd9,        5'd4,  1'b1, 4'b1000, 1'b1};
        vecs[2]  = '{1'b0,1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     5'd0, 5'd5, 5'd3,  SLT_, 1'b0, 1'b0, 4'b1000, 2'd0, 2'd0,  32'd1,         32'd1,        5'd5,  1'b0, 4'b1000, 1'b1};
        vecs[3]  = '{1'b0,1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,     5'd0, 5'd5, 5'd3,  SLT_, 1'b0, 1'b0, 4'b1000, 2'd0, 2'd0,  32'd0,         32'hFFFFFFFF, 5'd5,  1'b1, 4'b1000, 1'b1};
        vecs[4]  = '{1'b0,1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     5'd0, 5'd1, 5'd7,  ADD_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd0,         32'd1,        5'd7,  1'b1, 4'b1000, 1'b1};
        vecs[5]  = '{1'b0,1'b0, 32'd123,      32'd1,        32'd0,        32'd0,     5'd4, 5'd1, 5'd8,  SLL_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd16,        32'd1,        5'd8,  1'b0, 4'b1000, 1'b1};
        vecs[6]  = '{1'b0,1'b0, 32'd10,       32'd55,       32'hFFFFFFFC, 32'd0,     5'd0, 5'd2, 5'd9,  ADD_, 1'b1, 1'b0, 4'b0010, 2'd0, 2'd0,  32'd6,         32'd55,       5'd2,  1'b0, 4'b0010, 1'b1};
        vecs[7]  = '{1'b0,1'b0, 32'd2,        32'd3,        32'd0,        32'd0,     5'd0, 5'd1, 5'd9,  ADD_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd5,         32'd3,        5'd9,  1'b0, 4'b1000, 1'b1};
        vecs[8]  = '{1'b0,1'b0, 32'd0,        32'd1,        32'd0,        32'd0,     5'd0, 5'd1, 5'd10, ADD_, 1'b0, 1'b1, 4'b1000, 2'd2, 2'd0,  32'd6,         32'd1,        5'd10, 1'b0, 4'b1000, 1'b1};
        vecs[9]  = '{1'b0,1'b0, 32'd1,        32'd0,        32'd0,        32'd100,   5'd0, 5'd1, 5'd11, OR_,  1'b0, 1'b1, 4'b1000, 2'd0, 2'd1,  32'd101,       32'd100,      5'd11, 1'b0, 4'b1000, 1'b1};
        vecs[10] = '{1'b0,1'b0, 32'd4,        32'd6,        32'd0,        32'd999,   5'd0, 5'd1, 5'd12, ADD_, 1'b0, 1'b1, 4'b1000, 2'd3, 2'd3,  32'd10,        32'd6,        5'd12, 1'b0, 4'b1000, 1'b1};
        vecs[11] = '{1'b0,1'b0, 32'hF0F0,     32'hFF00,     32'd0,        32'd0,     5'd0, 5'd1, 5'd13, AND_, 1'b0, 1'b1, 4'b1101, 2'd0, 2'd0,  32'hF000,      32'hFF00,     5'd13, 1'b0, 4'b1101, 1'b1};
        vecs[12] = '{1'b0,1'b0, 32'd5,        32'd7,        32'd0,        32'd0,     5'd0, 5'd9, 5'd3,  ADD_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd12,        32'd7,        5'd3,  1'b0, 4'b1000, 1'b1};
        vecs[13] = '{1'b1,1'b0, 32'd1,        32'd1,        32'd0,        32'd0,     5'd0, 5'd1, 5'd20, ADD_, 1'b0, 1'b1, 4'b0110, 2'd0, 2'd0,  32'd12,        32'd7,        5'd3,  1'b0, 4'b1000, 1'b1};
        vecs[14] = '{1'b1,1'b0, 32'd0,        32'd0,        32'd0,        32'd0,     5'd0, 5'd2, 5'd21, SUB_, 1'b0, 1'b0, 4'b0001, 2'd0, 2'd0,  32'd12,        32'd7,        5'd3,  1'b0, 4'b1000, 1'b1};
        vecs[15] = '{1'b1,1'b0, 32'd8,        32'd8,        32'd0,        32'd0,     5'd0, 5'd3, 5'd22, OR_,  1'b0, 1'b1, 4'b1111, 2'd2, 2'd2,  32'd12,        32'd7,        5'd3,  1'b0, 4'b1000, 1'b1};
        vecs[16] = '{1'b0,1'b0, 32'd0,        32'd1,        32'd0,        32'd0,     5'd0, 5'd1, 5'd14, ADD_, 1'b0, 1'b1, 4'b1000, 2'd2, 2'd0,  32'd13,        32'd1,        5'd14, 1'b0, 4'b1000, 1'b1};
        vecs[17] = '{1'b1,1'b1, 32'd3,        32'd4,        32'd0,        32'd0,     5'd0, 5'd1, 5'd16, ADD_, 1'b0, 1'b1, 4'b1111, 2'd0, 2'd0,  32'd0,         32'd0,        5'd0,  1'b0, 4'b0000, 1'b0};
        vecs[18] = '{1'b0,1'b0, 32'd20,       32'd22,       32'd0,        32'd0,     5'd0, 5'd1, 5'd15, ADD_, 1'b0, 1'b1, 4'b1000, 2'd0, 2'd0,  32'd42,        32'd22,       5'd15, 1'b0, 4'b1000, 1'b1};
        vecs[19] = '{1'b0,1'b0, 32'd7,        32'd8,        32'd0,        32'd0,     5'd0, 5'd6, 5'd15, SUB_, 1'b0, 1'b0, 4'b1000, 2'd2, 2'd2,  32'd0,         32'd42,       5'd6,  1'b1, 4'b1000, 1'b1};

        // Reset state
        v = vecs[0];
        drive(v);
        reset = 1'b1;
        tick();
        tick();
        check_out("reset", 32'd0, 32'd0, 5'd0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_wd, vecs[i].e_dest,
                      vecs[i].e_zero, vecs[i].e_ctrl, vecs[i].e_valid);
        end

        // Reset mid-stream with a register-writing instruction in flight
        v = vecs[0];
        drive(v);
        tick();
        check_out("pre_reset", 32'd12, 32'd7, 5'd3, 1'b0, 4'b1000, 1'b1);
        v.rs = 32'd100;
        drive(v);
        reset = 1'b1;
        tick();
        check_out("mid_reset", 32'd0, 32'd0, 5'd0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;
        v.rs  = 32'd5;
        v.rt  = 32'd5;
        v.ctl = 4'b1111;
        drive(v);
        tick();
        check_out("post_reset_undef", 32'd0, 32'd5, 5'd3, 1'b1, 4'b1000, 1'b1);

        // Randomized run against the reference model
        ctls = '{AND_, OR_, ADD_, SLL_, SUB_, SLT_, 4'b1111};
        m_res = '0; m_wd = '0; m_dest = '0; m_zero = 1'b0; m_ctrl = '0; m_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset   = (n == 0) || ($urandom_range(63) == 0);
            stall   = ($urandom_range(7) == 0);
            flush   = ($urandom_range(15) == 0);
            if ($urandom_range(1) == 1) begin
                rs_data = $urandom_range(3);
                rt_data = $urandom_range(3);
            end else begin
                rs_data = $urandom;
                rt_data = $urandom;
            end
            imm     = $urandom;
            wb_data = $urandom;
            shamt   = 5'($urandom);
            rt_addr = 5'($urandom);
            rd_addr = 5'($urandom);
            alu_ctl = ($urandom_range(5) == 0) ? 4'($urandom) : ctls[$urandom_range(6)];
            alu_src = 1'($urandom);
            reg_dst = 1'($urandom);
            {reg_write, mem_read, mem_write, mem_to_reg} = 4'($urandom);
            fwd_a   = 2'($urandom);
            fwd_b   = 2'($urandom);

            a   = (fwd_a == 2'd2) ? m_res : (fwd_a == 2'd1) ? wb_data : rs_data;
            rtv = (fwd_b == 2'd2) ? m_res : (fwd_b == 2'd1) ? wb_data : rt_data;
            b   = alu_src ? imm : rtv;
            r   = ref_alu(alu_ctl, a, b, rtv, shamt);

            if (reset || flush) begin
                m_res = '0; m_wd = '0; m_dest = '0; m_zero = 1'b0; m_ctrl = '0; m_valid = 1'b0;
            end else if (!stall) begin
                m_res   = r;
                m_wd    = rtv;
                m_dest  = reg_dst ? rd_addr : rt_addr;
                m_zero  = (r == 32'd0);
                m_ctrl  = {reg_write, mem_read, mem_write, mem_to_reg};
                m_valid = 1'b1;
            end
            tick();
            check_out($sformatf("rnd%0d", n), m_res, m_wd, m_dest, m_zero, m_ctrl, m_valid);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX operands plus the 4-bit ALUctl code produced by the ALU control unit. Applies forwarding muxes and computes the ALU result and zero flag. Registers everything into the EX/MEM pipeline register, with stall hold and flush-to-bubble support.

Parameters:
DATA_W, 32, datapath width (shift amount field is fixed at 5 bits)
REG_AW, 5, register-file address width

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold EX/MEM contents this cycle
flush  in  1  load bubble into EX/MEM this cycle
rs_data  in  DATA_W  ID/EX rs register value
rt_data  in  DATA_W  ID/EX rt register value
imm  in  DATA_W  ID/EX sign-extended immediate
shamt  in  5  ID/EX shift amount field
rt_addr  in  REG_AW  ID/EX rt field
rd_addr  in  REG_AW  ID/EX rd field
alu_ctl  in  4  code from ALU control: 0000 AND, 0001 OR, 0010 ADD, 0100 SLL, 0110 SUB, 0111 SLT
alu_src  in  1  1: operand B = imm; 0: operand B = forwarded rt
reg_dst  in  1  1: dest = rd_addr; 0: dest = rt_addr
reg_write, mem_read, mem_write, mem_to_reg  in  1 each  ID/EX control bits
fwd_a, fwd_b  in  2 each  forwarding select from hazard unit
wb_data  in  DATA_W  MEM/WB writeback value for forwarding
ex_mem_alu_result  out  DATA_W  registered ALU result
ex_mem_write_data  out  DATA_W  registered forwarded rt (store data)
ex_mem_dest  out  REG_AW  registered destination register
ex_mem_zero  out  1  registered (result == 0)
ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg  out  1 each  registered control
ex_mem_valid  out  1  1 = real instruction, 0 = bubble

Behaviour:
- Forward mux A on rs_data: 00 -> rs_data; 10 -> current ex_mem_alu_result; 01 -> wb_data; 11 -> rs_data.
- Forward mux B on rt_data uses the same encoding to give fwd_rt.
- opB = alu_src ? imm : fwd_rt. Store data is always fwd_rt, regardless of alu_src.
- ALU, combinational:
  - AND: a&opB
  - OR: a|opB
  - ADD: a+opB, mod 2^32, no overflow trap
  - SUB: a-opB, mod 2^32
  - SLT: signed compare, result 32'd1 or 32'd0
  - SLL: fwd_rt << shamt. Uses fwd_rt, not opB; rs is ignored.
  - Any other code: result 0.
- zero = (result == 0). It is computed for every op.
- dest = reg_dst ? rd_addr : rt_addr.
- Latency: inputs sampled at edge N appear on ex_mem_* after edge N.
- Update priority, evaluated per rising edge:
  - reset: all outputs 0, including ex_mem_valid=0.
  - Else flush: control outputs and valid go to 0, data outputs go to 0. Flush overrides stall.
  - Else stall: all ex_mem_* hold their previous values.
  - Else: load computed values, with ex_mem_valid=1.
- During stall, forwarding select 10 sees the held ex_mem_alu_result.
- No internal state beyond the EX/MEM register. Reset mid-stream discards the in-flight instruction; the first post-reset cycle loads normally.
- Load-use hazards are not resolved here. The hazard unit must stall; the block forwards whatever the selects dictate.
- A bubble (valid=0) must have reg_write=mem_write=mem_read=0.

Test Plan:
- ADD: rs=5, rt=7, alu_ctl=0010, alu_src=0, reg_dst=1, rd=3, fwd=00 -> next cycle result=12, dest=3, zero=0, valid=1.
- SUB/SLT:
  - SUB 9-9 -> result 0, zero=1.
  - SLT rs=32'hFFFFFFFF, rt=1 -> result 1.
  - SLT rs=1, rt=32'hFFFFFFFF -> result 0.
  - ADD 32'hFFFFFFFF+1 -> result 0, zero=1.
- SLL and immediate:
  - rt=1, shamt=4, alu_ctl=0100 -> 16, rs value ignored.
  - alu_src=1, imm=32'hFFFFFFFC, rs=10, ADD -> 6.
  - Store path: write_data=rt, not imm.
- Forwarding:
  - Cycle 1: ADD 2+3 -> result 5.
  - Cycle 2: fwd_a=10, rs_data=0, rt=1, ADD -> 6.
  - fwd_b=01, wb_data=100, alu_src=0, OR with rs=1 -> 101.
  - fwd=11 behaves as 00.
- Stall/flush:
  - Load result 12, assert stall 3 cycles with new inputs -> outputs stay 12 throughout.
  - Assert stall+flush together -> bubble: valid=0, all control 0, data 0.
  - Deassert both -> next instruction loads.
- Reset: mid-stream with reg_write=1 in flight, assert reset one cycle -> all outputs 0 next edge. Release -> normal loading resumes next cycle; undefined alu_ctl=1111 gives result 0, zero=1.
